// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_D = 32;
    localparam int NREG_D = 32;
    localparam int NRD_D  = 2;

    // Address width for a register count; at least 1 bit so NREG=2 still has a port.
    function automatic int aw_of(input int nreg);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < nreg) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, write clears, issue wins on a same-cycle collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_D,
    localparam int AW   = aw_of(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (we0 && (wa0 != '0)) busy_d[wa0] = 1'b0;
        if (we1 && (wa1 != '0)) busy_d[wa1] = 1'b0;
        // Applied last: the newly issued producer outranks the completing write.
        if (iss_v && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with write-through bypass and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_D,
    parameter  int NREG = NREG_D,
    parameter  int NRD  = NRD_D,
    localparam int AW   = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_v,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr0_en;
    logic            wr1_en;

    // Gated by rst_n so a write presented during reset neither lands nor bypasses.
    assign wr0_en = we0 && rst_n && (wa0 != '0);
    assign wr1_en = we1 && rst_n && (wa1 != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[wa0] = wd0;
        if (wr1_en) regs_d[wa1] = wd1;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // iss_v has no ready: every issue is accepted in the cycle it is presented.
    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit0;
        logic          hit1;

        assign addr = ra[p*AW +: AW];
        assign hit0 = wr0_en && (wa0 == addr);
        assign hit1 = wr1_en && (wa1 == addr);

        assign rd[p*XLEN +: XLEN] = (addr == '0) ? '0 :
                                    hit1         ? wd1 :
                                    hit0         ? wd0 :
                                                   regs_q[addr];

        // busy_vec[0] is constant 0, so reads of register 0 never report busy.
        assign rd_busy[p] = busy_vec[addr] & ~(hit0 | hit1);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: driver pushes expectations, negedge monitor checks them.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    localparam int SEL_RD0   = 0;
    localparam int SEL_RD1   = 1;
    localparam int SEL_RBUSY = 2;
    localparam int SEL_BVEC  = 3;

    logic                clk;
    logic                rst_n;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic                iss_v;
    logic [AW-1:0]       iss_rd;
    logic [NREG-1:0]     busy_vec;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          n_checks;
    int          n_pass;

    regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .iss_v    (iss_v),
        .iss_rd   (iss_rd),
        .busy_vec (busy_vec)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_rd = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    task automatic expect_val(input int sel, input logic [31:0] val, input string name);
        sel_q.push_back(sel);
        exp_q.push_back(val);
        name_q.push_back(name);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            int          sel;
            logic [31:0] exp_v;
            logic [31:0] act;
            string       nm;
            sel   = sel_q.pop_front();
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            case (sel)
                SEL_RD0:   act = rd[31:0];
                SEL_RD1:   act = rd[63:32];
                SEL_RBUSY: act = {30'b0, rd_busy};
                default:   act = busy_vec;
            endcase
            n_checks++;
            if (act === exp_v) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        idle();
        set_ra(5'd5, 5'd4);

        // Writes/issues presented while in reset must be invisible.
        #2;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA_5555;
        iss_v = 1'b1; iss_rd = 5'd4;
        expect_val(SEL_RD0,   32'h0, "reset_rd0");
        expect_val(SEL_RD1,   32'h0, "reset_rd1");
        expect_val(SEL_RBUSY, 32'h0, "reset_rd_busy");
        expect_val(SEL_BVEC,  32'h0, "reset_busy_vec");
        step();
        step();
        rst_n = 1'b1;
        idle();
        expect_val(SEL_RD0,  32'h0, "reset_write_ignored");
        expect_val(SEL_BVEC, 32'h0, "reset_issue_ignored");

        // Reset then write (and bypass in the write cycle).
        step();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        expect_val(SEL_RD0, 32'hDEAD_BEEF, "wr5_bypass");
        step();
        idle();
        expect_val(SEL_RD0, 32'hDEAD_BEEF, "wr5_readback");
        expect_val(SEL_BVEC, 32'h0, "wr_not_busy_stays_0");

        // Zero register ignores writes.
        step();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1234;
        set_ra(5'd0, 5'd5);
        expect_val(SEL_RD0, 32'h0, "r0_write_bypass");
        step();
        idle();
        expect_val(SEL_RD0,  32'h0, "r0_readback");
        expect_val(SEL_BVEC, 32'h0, "r0_busy_bit");

        // Dual-write conflict: port 1 wins both in bypass and in the array.
        step();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2;
        set_ra(5'd7, 5'd7);
        expect_val(SEL_RD0, 32'h2, "dual_wr_bypass_rd0");
        expect_val(SEL_RD1, 32'h2, "dual_wr_bypass_rd1");
        step();
        idle();
        expect_val(SEL_RD0, 32'h2, "dual_wr_readback");

        // Scoreboard set, read-side busy, clear by write with bypass.
        step();
        iss_v = 1'b1; iss_rd = 5'd9;
        set_ra(5'd7, 5'd9);
        expect_val(SEL_RBUSY, 32'h0, "issue_cycle_not_busy_yet");
        expect_val(SEL_BVEC,  32'h0, "issue_cycle_bvec");
        step();
        idle();
        expect_val(SEL_BVEC,  32'h0000_0200, "busy9_set");
        expect_val(SEL_RBUSY, 32'h2, "rd_busy1_set");
        step();
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hCAFE_0009;
        expect_val(SEL_RBUSY, 32'h0, "rd_busy1_cleared_by_write");
        expect_val(SEL_RD1,   32'hCAFE_0009, "rd1_bypass_wd0");
        expect_val(SEL_BVEC,  32'h0000_0200, "bvec_no_bypass");
        step();
        idle();
        expect_val(SEL_BVEC, 32'h0, "busy9_cleared");
        expect_val(SEL_RD1,  32'hCAFE_0009, "reg9_readback");

        // Issue/write collision: busy set wins, data still written.
        step();
        iss_v = 1'b1; iss_rd = 5'd3;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_0033;
        set_ra(5'd3, 5'd9);
        expect_val(SEL_RD0,   32'h33, "collide_bypass");
        expect_val(SEL_RBUSY, 32'h0, "collide_rd_busy");
        step();
        idle();
        expect_val(SEL_BVEC,  32'h0000_0008, "collide_busy3_set");
        expect_val(SEL_RD0,   32'h33, "collide_reg3_written");
        expect_val(SEL_RBUSY, 32'h1, "collide_rd_busy0");

        // Issue to register 0 is ignored.
        step();
        iss_v = 1'b1; iss_rd = 5'd0;
        step();
        idle();
        expect_val(SEL_BVEC, 32'h0000_0008, "issue_r0_ignored");

        // Fill every register and mark each busy (issue + write collide each cycle).
        for (int i = 1; i < NREG; i++) begin
            step();
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'h0101_0101 * i;
            iss_v = 1'b1; iss_rd = AW'(i);
        end
        step();
        idle();
        set_ra(5'd31, 5'd17);
        expect_val(SEL_BVEC,  32'hFFFF_FFFE, "fill_all_busy");
        expect_val(SEL_RD0,   32'h1F1F_1F1F, "fill_reg31");
        expect_val(SEL_RD1,   32'h1111_1111, "fill_reg17");
        expect_val(SEL_RBUSY, 32'h3, "fill_rd_busy");

        // Asynchronous reset between edges, with a bypassing write still presented.
        step();
        we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h7777_7777;
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(SEL_RD0,   32'h0, "async_rst_rd0");
        expect_val(SEL_RD1,   32'h0, "async_rst_rd1");
        expect_val(SEL_RBUSY, 32'h0, "async_rst_rd_busy");
        expect_val(SEL_BVEC,  32'h0, "async_rst_bvec");
        step();
        rst_n = 1'b1;
        idle();
        expect_val(SEL_RD0,  32'h0, "post_rst_reg31");
        expect_val(SEL_RD1,  32'h0, "post_rst_reg17");
        expect_val(SEL_BVEC, 32'h0, "post_rst_bvec");

        // First edge after release works normally.
        step();
        we1 = 1'b1; wa1 = 5'd17; wd1 = 32'h0BAD_F00D;
        iss_v = 1'b1; iss_rd = 5'd31;
        step();
        idle();
        expect_val(SEL_RD1,  32'h0BAD_F00D, "post_rst_write");
        expect_val(SEL_BVEC, 32'h8000_0000, "post_rst_issue");

        step();
        step();
        if (sel_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", sel_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog: the directed sequence is short, so this only fires on a stall.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning the register count, a power of two >= 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning the read-port count, in the range 1..4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports we0, wa0, wd0 (input, 1 / AW / XLEN bits) and we1, wa1, wd1 (input, 1 / AW / XLEN bits): write ports 0 and 1.
REQ-007 SHALL have port ra, input, NRD*AW bits: read addresses; port i uses bits [i*AW +: AW].
REQ-008 SHALL have port rd, output, NRD*XLEN bits: read data; port i uses bits [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy, output, NRD bits: bit i is the scoreboard-pending flag for ra port i.
REQ-010 SHALL have ports iss_v (input, 1 bit) and iss_rd (input, AW bits): issue of an instruction whose destination is iss_rd.
REQ-011 SHALL have port busy_vec, output, NREG bits: the full scoreboard.

Function
REQ-012 Register 0 SHALL read as 0 at all times and SHALL ignore writes and issues.
REQ-013 A write port with weN=1 and waN!=0 SHALL update reg[waN] at the rising clock edge.
REQ-014 When both write ports target the same nonzero address in the same cycle, port 1 SHALL win.
REQ-015 Reads SHALL be combinational, with zero-cycle latency.
REQ-016 When a same-cycle write targets ra_i (nonzero), rd_i SHALL return that write data (write-through bypass); port 1 data SHALL take precedence over port 0.
REQ-017 iss_v=1 with iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-018 A write with weN=1 and waN!=0 SHALL clear busy[waN] at the same edge the data is written.
REQ-019 When an issue and a write target the same address in the same cycle, the busy set SHALL win (the newer producer); the data write SHALL still occur.
REQ-020 rd_busy[i] SHALL equal busy[ra_i] AND NOT (a same-cycle write to ra_i), and SHALL be 0 for ra_i = 0.
REQ-021 busy_vec SHALL reflect registered busy bits only, with no bypass; bit 0 SHALL always be 0.
REQ-022 A write to an address that is not busy SHALL be legal, SHALL update data, and SHALL leave busy at 0.

Reset
REQ-023 While rst_n=0, all registers and all busy bits SHALL be 0 immediately, independent of clk.
REQ-024 While rst_n=0, rd SHALL be all 0 and rd_busy and busy_vec SHALL be 0; writes and issues SHALL be ignored.
REQ-025 On the first rising edge after rst_n deasserts, writes and issues SHALL take effect normally.
REQ-026 Reset asserted mid-operation SHALL discard pending busy bits and register contents without any partial update.

Structure
REQ-027 Package regfile_pkg SHALL hold the default constants XLEN_D=32, NREG_D=32, NRD_D=2 and the AW derivation function.
REQ-028 The scoreboard (busy bits, set/clear priority, busy_vec) SHALL be the sub-module regfile_scoreboard; the data array and bypass muxes SHALL live in regfile_sb.
REQ-029 The data array SHALL be flops with asynchronous clear, not inferred RAM, so that the reset requirement is honoured.

Verification
REQ-030 Reset then write: after rst_n release, we0=1, wa0=5, wd0=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF.
REQ-031 Zero register: we1=1, wa1=0, wd1=0x1234; then ra0=0 -> rd0=0 and busy_vec[0]=0.
REQ-032 Dual-write conflict: wa0=wa1=7, wd0=0x1, wd1=0x2, both enabled; in the same cycle ra0=7 -> rd0=0x2 (bypass); next cycle still 0x2.
REQ-033 Scoreboard: iss_v=1, iss_rd=9 -> busy_vec[9]=1 next cycle; with ra1=9, rd_busy[1]=1; write wa0=9 -> in that cycle rd_busy[1]=0 and rd1=wd0; next cycle busy_vec[9]=0.
REQ-034 Issue/write collision: iss_rd=3 and wa1=3 in the same cycle -> busy_vec[3]=1 and reg[3]=wd1 afterwards.
REQ-035 Asynchronous reset mid-stream: with regs 1..31 and busy bits set, drop rst_n between edges -> rd, busy_vec and rd_busy are all 0 before the next clk edge.
